// File: rtl/breakpoint_controller.sv
// Breakpoint responder for the (instance_id, stmt_id) trace stream: stalls on a
// table match or in single-step mode and holds the event until the debugger resumes.
module breakpoint_controller #(
   parameter int unsigned NUM_BP     = 4,
   parameter int unsigned ID_WIDTH   = 32,
   parameter int unsigned STMT_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  trace_valid,
   output logic                  trace_ready,
   input  logic [ID_WIDTH-1:0]   trace_instance_id,
   input  logic [STMT_WIDTH-1:0] trace_stmt_id,
   input  logic                  cfg_we,
   input  logic [3:0]            cfg_index,
   input  logic                  cfg_enable,
   input  logic                  cfg_any_inst,
   input  logic [ID_WIDTH-1:0]   cfg_instance_id,
   input  logic [STMT_WIDTH-1:0] cfg_stmt_id,
   input  logic                  step_en,
   input  logic                  resume,
   output logic                  halted,
   output logic [4:0]            hit_index,
   output logic [ID_WIDTH-1:0]   hit_instance_id,
   output logic [STMT_WIDTH-1:0] hit_stmt_id,
   output logic [CNT_WIDTH-1:0]  hit_count
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HALTED  = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

   state_e                state_q;
   logic                  en_q   [NUM_BP];
   logic                  any_q  [NUM_BP];
   logic [ID_WIDTH-1:0]   inst_q [NUM_BP];
   logic [STMT_WIDTH-1:0] stmt_q [NUM_BP];

   logic                  halted_q;
   logic [4:0]            hit_index_q;
   logic [ID_WIDTH-1:0]   hit_inst_q;
   logic [STMT_WIDTH-1:0] hit_stmt_q;
   logic [CNT_WIDTH-1:0]  hit_count_q;

   logic       match_found;
   logic [4:0] match_idx;
   logic       halt_req;

   // Priority match against the current table; descending scan lets the lowest index win.
   always_comb begin
      match_found = 1'b0;
      match_idx   = 5'd0;
      for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
         if (en_q[i] && (stmt_q[i] == trace_stmt_id) &&
             (any_q[i] || (inst_q[i] == trace_instance_id))) begin
            match_found = 1'b1;
            match_idx   = 5'(i);
         end
      end
   end

   always_comb begin
      halt_req    = 1'b0;
      trace_ready = 1'b0;
      case (state_q)
         ST_RUN: begin
            halt_req    = trace_valid && (match_found || step_en);
            trace_ready = !halt_req;
         end
         ST_HALTED:  trace_ready = 1'b0;
         ST_RELEASE: trace_ready = 1'b1;
         default:    trace_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         halted_q    <= 1'b0;
         hit_index_q <= 5'd0;
         hit_inst_q  <= '0;
         hit_stmt_q  <= '0;
         hit_count_q <= '0;
         for (int i = 0; i < int'(NUM_BP); i++) begin
            en_q[i]   <= 1'b0;
            any_q[i]  <= 1'b0;
            inst_q[i] <= '0;
            stmt_q[i] <= '0;
         end
      end else begin
         // Out-of-range indices never compare equal, so such writes drop out.
         for (int i = 0; i < int'(NUM_BP); i++) begin
            if (cfg_we && (cfg_index == 4'(i))) begin
               en_q[i]   <= cfg_enable;
               any_q[i]  <= cfg_any_inst;
               inst_q[i] <= cfg_instance_id;
               stmt_q[i] <= cfg_stmt_id;
            end
         end
         case (state_q)
            ST_RUN: begin
               if (halt_req) begin
                  state_q     <= ST_HALTED;
                  halted_q    <= 1'b1;
                  hit_index_q <= match_found ? match_idx : 5'(NUM_BP);
                  hit_inst_q  <= trace_instance_id;
                  hit_stmt_q  <= trace_stmt_id;
                  if (hit_count_q != '1) hit_count_q <= hit_count_q + CNT_WIDTH'(1);
               end
            end
            ST_HALTED: begin
               if (resume) begin
                  state_q  <= ST_RELEASE;
                  halted_q <= 1'b0;
               end
            end
            ST_RELEASE: begin
               if (trace_valid) state_q <= ST_RUN;
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign halted          = halted_q;
   assign hit_index       = hit_index_q;
   assign hit_instance_id = hit_inst_q;
   assign hit_stmt_id     = hit_stmt_q;
   assign hit_count       = hit_count_q;

endmodule

// File: tb/tb_breakpoint_controller.sv
// Bench for breakpoint_controller: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the halt/release protocol.
module tb_breakpoint_controller;

   localparam int unsigned NUM_BP = 4;
   localparam int unsigned CW     = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        trace_valid;
   logic        trace_ready;
   logic [31:0] trace_instance_id;
   logic [31:0] trace_stmt_id;
   logic        cfg_we;
   logic [3:0]  cfg_index;
   logic        cfg_enable;
   logic        cfg_any_inst;
   logic [31:0] cfg_instance_id;
   logic [31:0] cfg_stmt_id;
   logic        step_en;
   logic        resume;
   logic        halted;
   logic [4:0]  hit_index;
   logic [31:0] hit_instance_id;
   logic [31:0] hit_stmt_id;
   logic [15:0] hit_count;

   breakpoint_controller dut (
      .clk(clk), .rst(rst),
      .trace_valid(trace_valid), .trace_ready(trace_ready),
      .trace_instance_id(trace_instance_id), .trace_stmt_id(trace_stmt_id),
      .cfg_we(cfg_we), .cfg_index(cfg_index), .cfg_enable(cfg_enable),
      .cfg_any_inst(cfg_any_inst), .cfg_instance_id(cfg_instance_id),
      .cfg_stmt_id(cfg_stmt_id), .step_en(step_en), .resume(resume),
      .halted(halted), .hit_index(hit_index), .hit_instance_id(hit_instance_id),
      .hit_stmt_id(hit_stmt_id), .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: breakpoint table plus "stopped" / "letting the held event through" flags.
   bit          t_en   [NUM_BP];
   bit          t_any  [NUM_BP];
   logic [31:0] t_inst [NUM_BP];
   logic [31:0] t_stmt [NUM_BP];
   bit          m_stopped, m_letting;
   int          m_idx;
   logic [31:0] m_inst, m_stmt;
   int          m_count;
   bit          last_acc;

   function automatic int find_hit();
      for (int i = 0; i < int'(NUM_BP); i++)
         if (t_en[i] && t_stmt[i] == trace_stmt_id && (t_any[i] || t_inst[i] == trace_instance_id))
            return i;
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(NUM_BP); i++) begin
         t_en[i] = 0; t_any[i] = 0; t_inst[i] = '0; t_stmt[i] = '0;
      end
      m_stopped = 0; m_letting = 0; m_idx = 0; m_inst = '0; m_stmt = '0; m_count = 0;
   endtask

   // One clock: check outputs at negedge, advance model, release at posedge+1.
   task automatic tick();
      int h;
      bit exp_rdy;
      @(negedge clk);
      h = find_hit();
      if (m_stopped)      exp_rdy = 0;
      else if (m_letting) exp_rdy = 1;
      else                exp_rdy = !(trace_valid && (h >= 0 || step_en));
      chk_eq("trace_ready", 64'(trace_ready), 64'(exp_rdy));
      chk_eq("halted", 64'(halted), 64'(m_stopped));
      chk_eq("hit_index", 64'(hit_index), 64'(m_idx));
      chk_eq("hit_instance_id", 64'(hit_instance_id), 64'(m_inst));
      chk_eq("hit_stmt_id", 64'(hit_stmt_id), 64'(m_stmt));
      chk_eq("hit_count", 64'(hit_count), 64'(m_count));
      last_acc = trace_valid && exp_rdy;
      if (rst) begin
         model_reset();
      end else begin
         if (!m_stopped && !m_letting) begin
            if (trace_valid && (h >= 0 || step_en)) begin
               m_stopped = 1;
               m_idx     = (h >= 0) ? h : int'(NUM_BP);
               m_inst    = trace_instance_id;
               m_stmt    = trace_stmt_id;
               if (m_count < (1 << CW) - 1) m_count++;
            end
         end else if (m_stopped) begin
            if (resume) begin m_stopped = 0; m_letting = 1; end
         end else if (trace_valid) begin
            m_letting = 0;
         end
         if (cfg_we && int'(cfg_index) < int'(NUM_BP)) begin
            t_en[cfg_index]   = cfg_enable;
            t_any[cfg_index]  = cfg_any_inst;
            t_inst[cfg_index] = cfg_instance_id;
            t_stmt[cfg_index] = cfg_stmt_id;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int idx, input bit en, input bit any,
                            input logic [31:0] inst, input logic [31:0] stmt);
      cfg_we = 1; cfg_index = 4'(idx); cfg_enable = en; cfg_any_inst = any;
      cfg_instance_id = inst; cfg_stmt_id = stmt;
      tick();
      cfg_we = 0;
   endtask

   task automatic put(input logic [31:0] inst, input logic [31:0] stmt);
      trace_valid = 1; trace_instance_id = inst; trace_stmt_id = stmt;
   endtask

   // Pulse resume, then let the held event through; exactly one acceptance expected.
   task automatic release_held();
      resume = 1; tick(); resume = 0;
      tick();
      chk_eq("release_accept", 64'(last_acc), 64'(1));
   endtask

   initial begin
      bit          pend;
      logic [31:0] pi, ps;
      rst = 1; trace_valid = 0; trace_instance_id = '0; trace_stmt_id = '0;
      cfg_we = 0; cfg_index = '0; cfg_enable = 0; cfg_any_inst = 0;
      cfg_instance_id = '0; cfg_stmt_id = '0; step_en = 0; resume = 0;
      model_reset();
      @(posedge clk); #1;
      tick(); tick();
      rst = 0;
      tick();
      chk_eq("reset_halted", 64'(halted), 64'(0));
      chk_eq("reset_count", 64'(hit_count), 64'(0));

      // Empty table: back-to-back events pass at one per cycle
      put(3, 0); tick(); chk_eq("t1_acc0", 64'(last_acc), 64'(1));
      put(2, 4); tick(); chk_eq("t1_acc1", 64'(last_acc), 64'(1));
      put(0, 7); tick(); chk_eq("t1_acc2", 64'(last_acc), 64'(1));
      trace_valid = 0; tick();
      chk_eq("t1_count", 64'(hit_count), 64'(0));

      // Exact match on entry 1, release, then the same event halts again
      cfg_write(1, 1, 0, 2, 5);
      put(2, 5); tick();
      chk_eq("t2_acc", 64'(last_acc), 64'(0));
      chk_eq("t2_halted", 64'(halted), 64'(1));
      chk_eq("t2_idx", 64'(hit_index), 64'(1));
      chk_eq("t2_inst", 64'(hit_instance_id), 64'(2));
      chk_eq("t2_stmt", 64'(hit_stmt_id), 64'(5));
      chk_eq("t2_count", 64'(hit_count), 64'(1));
      resume = 0; tick(); tick();
      chk_eq("t2_still_halted", 64'(halted), 64'(1));
      release_held();
      tick();
      chk_eq("t2_count2", 64'(hit_count), 64'(2));
      release_held();
      trace_valid = 0; tick();

      // Priority: any_inst entry 0 beats entry 2; with 0 disabled entry 2 wins
      cfg_write(0, 1, 1, 9, 32'hA);
      cfg_write(2, 1, 0, 0, 32'hA);
      put(0, 32'hA); tick();
      chk_eq("t3_idx0", 64'(hit_index), 64'(0));
      release_held();
      trace_valid = 0;
      cfg_write(0, 0, 1, 9, 32'hA);
      put(0, 32'hA); tick();
      chk_eq("t3_idx2", 64'(hit_index), 64'(2));
      release_held();
      trace_valid = 0; tick();

      // Single-step: every event halts with hit_index = NUM_BP
      step_en = 1;
      put(1, 32'hB); tick();
      chk_eq("t4_idx_b", 64'(hit_index), 64'(NUM_BP));
      resume = 1; tick(); resume = 0;
      trace_valid = 0; tick(); tick();          // RELEASE waits for valid
      put(1, 32'hB); tick();
      chk_eq("t4_acc_b", 64'(last_acc), 64'(1));
      put(1, 32'hC); tick();
      chk_eq("t4_idx_c", 64'(hit_index), 64'(NUM_BP));
      chk_eq("t4_stmt_c", 64'(hit_stmt_id), 64'(32'hC));
      release_held();
      step_en = 0; trace_valid = 0; tick();

      // Disabling the hit entry keeps the halt; reset clears everything
      cfg_write(1, 1, 0, 2, 6);
      put(2, 6); tick();
      chk_eq("t5_halted", 64'(halted), 64'(1));
      cfg_write(1, 0, 0, 2, 6);
      tick();
      chk_eq("t5_still_halted", 64'(halted), 64'(1));
      rst = 1; tick(); rst = 0;
      chk_eq("t5_rst_halted", 64'(halted), 64'(0));
      chk_eq("t5_rst_count", 64'(hit_count), 64'(0));
      tick();
      chk_eq("t5_acc", 64'(last_acc), 64'(1));
      trace_valid = 0; tick();

      // Same-cycle write uses the old table; out-of-range index is ignored
      cfg_we = 1; cfg_index = 3; cfg_enable = 1; cfg_any_inst = 0;
      cfg_instance_id = 1; cfg_stmt_id = 32'hF;
      put(1, 32'hF); tick(); cfg_we = 0;
      chk_eq("t6_acc_prewrite", 64'(last_acc), 64'(1));
      tick();
      chk_eq("t6_idx3", 64'(hit_index), 64'(3));
      release_held();
      trace_valid = 0;
      cfg_write(7, 1, 1, 0, 32'h7);
      put(1, 32'h7); tick();
      chk_eq("t6_oob_acc", 64'(last_acc), 64'(1));
      trace_valid = 0; tick();

      // Random traffic; the producer holds each event until it is accepted
      pend = 0; pi = '0; ps = '0;
      for (int n = 0; n < 3000; n++) begin
         if (!pend && $urandom_range(9) < 6) begin
            pend = 1; pi = 32'($urandom_range(3)); ps = 32'($urandom_range(15));
         end
         trace_valid = pend; trace_instance_id = pi; trace_stmt_id = ps;
         cfg_we = ($urandom_range(9) == 0);
         cfg_index = 4'($urandom_range(7));
         cfg_enable = ($urandom_range(3) != 0);
         cfg_any_inst = ($urandom_range(3) == 0);
         cfg_instance_id = 32'($urandom_range(3));
         cfg_stmt_id = 32'($urandom_range(15));
         step_en = ($urandom_range(15) == 0);
         resume = ($urandom_range(4) == 0);
         rst = ($urandom_range(199) == 0);
         tick();
         if (last_acc || rst) pend = 0;
      end
      rst = 0; cfg_we = 0; resume = 0; step_en = 0; trace_valid = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
